// File: rtl/axil_cfg_pkg.sv
// Shared types and constants for the AXI-Lite to cfg_bus bridge.
package axil_cfg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RD_RESP = 3'd5
  } state_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

endpackage

// File: rtl/axil_cfg_skid1.sv
// Single-entry valid/ready holding buffer. Ready is the inverse of the full
// flag (held low during reset); the entry is released by an external clear
// once the owning transaction has been answered.
module axil_cfg_skid1 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         clr,
  output logic         full,
  output logic [W-1:0] data
);

  logic take;

  assign in_ready = !full && !rst;
  assign take     = in_valid && in_ready;

  // Occupancy flag: set on accept, cleared by the response handshake.
  always_ff @(posedge clk) begin
    if (rst)       full <= 1'b0;
    else if (clr)  full <= 1'b0;
    else if (take) full <= 1'b1;
  end

  // Payload capture; only meaningful while full is set.
  always_ff @(posedge clk) begin
    if (take) data <= in_data;
  end

endmodule

// File: rtl/axil_cfg_bridge.sv
// AXI-Lite slave to cfg_bus master bridge. One outstanding transaction,
// alternating read/write grant under contention, optional ack timeout that
// answers with SLVERR.
module axil_cfg_bridge
  import axil_cfg_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr_i,
  input  logic                    s_awvalid_i,
  output logic                    s_awready_o,
  input  logic [DATA_WIDTH-1:0]   s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb_i,
  input  logic                    s_wvalid_i,
  output logic                    s_wready_o,
  output logic [1:0]              s_bresp_o,
  output logic                    s_bvalid_o,
  input  logic                    s_bready_i,
  input  logic [ADDR_WIDTH-1:0]   s_araddr_i,
  input  logic                    s_arvalid_i,
  output logic                    s_arready_o,
  output logic [DATA_WIDTH-1:0]   s_rdata_o,
  output logic [1:0]              s_rresp_o,
  output logic                    s_rvalid_o,
  input  logic                    s_rready_i,
  output logic [ADDR_WIDTH-1:0]   cfg_addr_o,
  output logic [DATA_WIDTH-1:0]   cfg_wdata_o,
  output logic [DATA_WIDTH/8-1:0] cfg_wstrb_o,
  output logic                    cfg_wr_o,
  output logic                    cfg_rd_o,
  input  logic                    cfg_ack_i,
  input  logic [DATA_WIDTH-1:0]   cfg_rdata_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [DATA_WIDTH-1:0] TO_RDATA = DATA_WIDTH'(TIMEOUT_RDATA);

  state_t                  state;
  grant_t                  last_grant;
  logic [CNT_W-1:0]        cnt;

  logic                    aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [STRB_WIDTH-1:0]   w_strb;
  logic                    wr_clr, rd_clr;
  logic                    wr_pend, rd_pend, grant_wr, timeout_hit;

  axil_cfg_skid1 #(.W(ADDR_WIDTH)) u_aw (
    .clk(clk_i), .rst(reset_i), .in_data(s_awaddr_i), .in_valid(s_awvalid_i),
    .in_ready(s_awready_o), .clr(wr_clr), .full(aw_full), .data(aw_addr)
  );

  axil_cfg_skid1 #(.W(DATA_WIDTH + STRB_WIDTH)) u_w (
    .clk(clk_i), .rst(reset_i), .in_data({s_wstrb_i, s_wdata_i}),
    .in_valid(s_wvalid_i), .in_ready(s_wready_o), .clr(wr_clr),
    .full(w_full), .data({w_strb, w_data})
  );

  axil_cfg_skid1 #(.W(ADDR_WIDTH)) u_ar (
    .clk(clk_i), .rst(reset_i), .in_data(s_araddr_i), .in_valid(s_arvalid_i),
    .in_ready(s_arready_o), .clr(rd_clr), .full(ar_full), .data(ar_addr)
  );

  assign wr_pend     = aw_full && w_full;
  assign rd_pend     = ar_full;
  // Under contention the side that did not win last time goes first.
  assign grant_wr    = wr_pend && (!rd_pend || (last_grant == GRANT_RD));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  assign wr_clr      = (state == ST_WR_RESP) && s_bready_i;
  assign rd_clr      = (state == ST_RD_RESP) && s_rready_i;

  assign cfg_wr_o    = (state == ST_WR_REQ);
  assign cfg_rd_o    = (state == ST_RD_REQ);
  assign s_bvalid_o  = (state == ST_WR_RESP);
  assign s_rvalid_o  = (state == ST_RD_RESP);

  // Transaction FSM: grant, request pulse, wait for ack or timeout, respond.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      last_grant  <= GRANT_RD;
      cnt         <= '0;
      s_bresp_o   <= RESP_OKAY;
      s_rresp_o   <= RESP_OKAY;
      s_rdata_o   <= '0;
      cfg_addr_o  <= '0;
      cfg_wdata_o <= '0;
      cfg_wstrb_o <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (wr_pend || rd_pend) begin
            cnt <= '0;
            if (grant_wr) begin
              state       <= ST_WR_REQ;
              last_grant  <= GRANT_WR;
              cfg_addr_o  <= aw_addr;
              cfg_wdata_o <= w_data;
              cfg_wstrb_o <= w_strb;
            end else begin
              state       <= ST_RD_REQ;
              last_grant  <= GRANT_RD;
              cfg_addr_o  <= ar_addr;
              cfg_wstrb_o <= '0;
            end
          end
        end
        ST_WR_REQ, ST_RD_REQ, ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cfg_ack_i) begin
            if (last_grant == GRANT_WR) begin
              s_bresp_o <= RESP_OKAY;
              state     <= ST_WR_RESP;
            end else begin
              s_rdata_o <= cfg_rdata_i;
              s_rresp_o <= RESP_OKAY;
              state     <= ST_RD_RESP;
            end
          end else if (timeout_hit) begin
            if (last_grant == GRANT_WR) begin
              s_bresp_o <= RESP_SLVERR;
              state     <= ST_WR_RESP;
            end else begin
              s_rdata_o <= TO_RDATA;
              s_rresp_o <= RESP_SLVERR;
              state     <= ST_RD_RESP;
            end
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WR_RESP: if (s_bready_i) state <= ST_IDLE;
        ST_RD_RESP: if (s_rready_i) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule
